exception_ctrl: RTL and testbench

Exception and processor-mode sequencer for the multi-cycle CPU. It owns the current mode `M` and the IRQ mask bit, and drives `M` into the register file for banked-register selection. At instruction boundaries it accepts undefined-instruction, SWI, IRQ and exception-return events. It stalls the main controller while it writes the banked LR and SPSR, then redirects the PC to the vector or the return address.

---
 rtl/exception_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_exception_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// Exception/mode sequencer: accepts UND/SWI/IRQ/ERET at instruction boundaries, banks LR/SPSR, redirects PC. IRQ path under EXC_IRQ_EN.
// Latency: entry pc_load 3 cycles after the accepting boundary, return pc_load 1 cycle after.
// Backpressure: stall holds the controller for the whole sequence; requests arriving outside IDLE are ignored.
module exception_ctrl #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_done,
  input  logic        und_ins,
  input  logic        swi_ins,
  input  logic        eret_req,
  input  logic        irq_req,
  input  logic [31:0] pc_in,
  input  logic [3:0]  nzcv_in,
  input  logic [31:0] lr_in,
  input  logic [31:0] spsr_in,
  input  logic        msr_we,
  input  logic [31:0] msr_data,
  output logic [4:0]  M,
  output logic        irq_mask,
  output logic        stall,
  output logic        lr_write,
  output logic [31:0] lr_data,
  output logic        spsr_write,
  output logic [31:0] spsr_data,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        nzcv_load,
  output logic [3:0]  nzcv_out,
  output logic        priv_err
);

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_UND = 5'b11011;

`ifdef EXC_IRQ_EN
  localparam logic IRQ_PATH = 1'b1;
`else
  localparam logic IRQ_PATH = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ENTER, S_SAVE, S_VECTOR, S_RET} state_t;
  typedef enum logic [1:0] {C_UND, C_SWI, C_IRQ} cause_t;

  state_t      state, state_nxt;
  cause_t      cause, cause_nxt;
  logic [4:0]  mode_q;
  logic        imask_q;
  logic [3:0]  old_nzcv;
  logic        old_i;
  logic [4:0]  old_m;
  logic [31:0] ret_addr;
  logic        accept;
  logic        msr_ok;
  logic        irq_take;
  logic        msr_legal;
  logic [4:0]  tgt_mode;
  logic [31:0] vec_addr;
  logic        unused_bits;

  assign irq_take  = IRQ_PATH & irq_req & ~imask_q;
  assign msr_legal = (msr_data[4:0] == MODE_USR) || (msr_data[4:0] == MODE_IRQ) ||
                     (msr_data[4:0] == MODE_SVC) || (msr_data[4:0] == MODE_UND);
  assign unused_bits = ^{msr_data[31:8], msr_data[6:5], spsr_in[27:8], spsr_in[6:5]};

  always_comb begin
    tgt_mode = MODE_UND;
    vec_addr = VEC_BASE + 32'h04;
    case (cause)
      C_SWI: begin
        tgt_mode = MODE_SVC;
        vec_addr = VEC_BASE + 32'h08;
      end
      C_IRQ: begin
        tgt_mode = MODE_IRQ;
        vec_addr = VEC_BASE + 32'h18;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cause_nxt  = cause;
    accept     = 1'b0;
    msr_ok     = 1'b0;
    stall      = 1'b0;
    lr_write   = 1'b0;
    lr_data    = 32'h0;
    spsr_write = 1'b0;
    spsr_data  = 32'h0;
    pc_load    = 1'b0;
    pc_target  = 32'h0;
    nzcv_load  = 1'b0;
    nzcv_out   = 4'h0;
    priv_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (inst_done) begin
          if (und_ins) begin
            state_nxt = S_ENTER;
            cause_nxt = C_UND;
            accept    = 1'b1;
          end else if (swi_ins) begin
            state_nxt = S_ENTER;
            cause_nxt = C_SWI;
            accept    = 1'b1;
          end else if (irq_take) begin
            state_nxt = S_ENTER;
            cause_nxt = C_IRQ;
            accept    = 1'b1;
          end else if (eret_req) begin
            if (mode_q == MODE_USR) priv_err = 1'b1;
            else                    state_nxt = S_RET;
          end
        end
        // MSR only lands when the boundary did not start a sequence.
        if (msr_we && state_nxt == S_IDLE) begin
          if (mode_q == MODE_USR || !msr_legal) priv_err = 1'b1;
          else                                  msr_ok   = 1'b1;
        end
      end
      S_ENTER: begin
        stall     = 1'b1;
        state_nxt = S_SAVE;
      end
      S_SAVE: begin
        stall      = 1'b1;
        lr_write   = 1'b1;
        lr_data    = ret_addr;
        spsr_write = 1'b1;
        spsr_data  = {old_nzcv, 20'h0, old_i, 2'b00, old_m};
        state_nxt  = S_VECTOR;
      end
      S_VECTOR: begin
        stall     = 1'b1;
        pc_load   = 1'b1;
        pc_target = vec_addr;
        state_nxt = S_IDLE;
      end
      S_RET: begin
        stall     = 1'b1;
        pc_load   = 1'b1;
        pc_target = lr_in;
        nzcv_load = 1'b1;
        nzcv_out  = spsr_in[31:28];
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A reset cycle aborts the sequence, so nothing may leave the block.
    if (rst) begin
      stall      = 1'b0;
      lr_write   = 1'b0;
      lr_data    = 32'h0;
      spsr_write = 1'b0;
      spsr_data  = 32'h0;
      pc_load    = 1'b0;
      pc_target  = 32'h0;
      nzcv_load  = 1'b0;
      nzcv_out   = 4'h0;
      priv_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cause    <= C_UND;
      mode_q   <= MODE_SVC;
      imask_q  <= 1'b1;
      old_nzcv <= 4'h0;
      old_i    <= 1'b0;
      old_m    <= 5'h0;
      ret_addr <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cause    <= cause_nxt;
        old_nzcv <= nzcv_in;
        old_i    <= imask_q;
        old_m    <= mode_q;
        ret_addr <= (cause_nxt == C_IRQ) ? pc_in + 32'd4 : pc_in;
      end
      case (state)
        S_ENTER:  mode_q  <= tgt_mode;
        S_VECTOR: imask_q <= 1'b1;
        S_RET: begin
          mode_q  <= spsr_in[4:0];
          imask_q <= spsr_in[7];
        end
        default: begin
          if (msr_ok) begin
            mode_q  <= msr_data[4:0];
            imask_q <= msr_data[7];
          end
        end
      endcase
    end
  end

  assign M        = mode_q;
  assign irq_mask = imask_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomized + directed bench for exception_ctrl against a boundary-level mode/flag model.
module tb_exception_ctrl;

  localparam logic [4:0] USR = 5'b10000;
  localparam logic [4:0] IRQ = 5'b10010;
  localparam logic [4:0] SVC = 5'b10011;
  localparam logic [4:0] UND = 5'b11011;
`ifdef EXC_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_done, und_ins, swi_ins, eret_req, irq_req, msr_we;
  logic [31:0] pc_in, lr_in, spsr_in, msr_data;
  logic [3:0]  nzcv_in;
  logic [4:0]  M;
  logic        irq_mask, stall, lr_write, spsr_write, pc_load, nzcv_load, priv_err;
  logic [31:0] lr_data, spsr_data, pc_target;
  logic [3:0]  nzcv_out;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] m_mode;
  logic       m_i;

  exception_ctrl dut (
    .clk(clk), .rst(rst), .inst_done(inst_done), .und_ins(und_ins), .swi_ins(swi_ins),
    .eret_req(eret_req), .irq_req(irq_req), .pc_in(pc_in), .nzcv_in(nzcv_in), .lr_in(lr_in),
    .spsr_in(spsr_in), .msr_we(msr_we), .msr_data(msr_data), .M(M), .irq_mask(irq_mask),
    .stall(stall), .lr_write(lr_write), .lr_data(lr_data), .spsr_write(spsr_write),
    .spsr_data(spsr_data), .pc_load(pc_load), .pc_target(pc_target), .nzcv_load(nzcv_load),
    .nzcv_out(nzcv_out), .priv_err(priv_err)
  );

  always #5 clk = ~clk;

  wire [5:0] strb = {stall, lr_write, spsr_write, pc_load, nzcv_load, priv_err};

  function automatic bit legal_mode(input logic [4:0] m);
    return (m == USR) || (m == IRQ) || (m == SVC) || (m == UND);
  endfunction

  // One instruction boundary; the model decides which event wins and checks the whole sequence.
  task automatic boundary(input logic u, input logic s, input logic e, input logic i,
                          input logic [31:0] pc, input logic [3:0] nz,
                          input logic [31:0] lr, input logic [31:0] sp);
    int          ev;
    logic [4:0]  tm;
    logic [31:0] ret, vec, esp;
    @(negedge clk);
    inst_done = 1'b1; und_ins = u; swi_ins = s; eret_req = e; irq_req = i;
    pc_in = pc; nzcv_in = nz; lr_in = lr; spsr_in = sp;
    if (u)                          ev = 1;
    else if (s)                     ev = 2;
    else if (i && !m_i && IRQ_EN)   ev = 3;
    else if (e)                     ev = (m_mode == USR) ? 5 : 4;
    else                            ev = 0;
    #1;
    vectors++;
    if (strb !== {5'b0, ev == 5}) begin
      miscompares++;
      $display("FAIL boundary_strobes ev=%0d: got %b want %b", ev, strb, {5'b0, ev == 5});
    end
    @(negedge clk);
    inst_done = 1'b0; und_ins = 1'b0; swi_ins = 1'b0; eret_req = 1'b0;
    #1;
    if (ev >= 1 && ev <= 3) begin
      tm  = (ev == 1) ? UND : (ev == 2) ? SVC : IRQ;
      vec = (ev == 1) ? 32'h4 : (ev == 2) ? 32'h8 : 32'h18;
      ret = (ev == 3) ? pc + 32'd4 : pc;
      esp = {nz, 20'h0, m_i, 2'b00, m_mode};
      vectors++;
      if ({strb, M} !== {6'b100000, m_mode}) begin
        miscompares++;
        $display("FAIL enter_cycle: got %b/%b want %b/%b", strb, M, 6'b100000, m_mode);
      end
      @(negedge clk); #1;
      vectors++;
      if ({strb, M, lr_data, spsr_data} !== {6'b111000, tm, ret, esp}) begin
        miscompares++;
        $display("FAIL save_cycle: got s=%b M=%b lr=%h spsr=%h want s=%b M=%b lr=%h spsr=%h",
                 strb, M, lr_data, spsr_data, 6'b111000, tm, ret, esp);
      end
      @(negedge clk); #1;
      vectors++;
      if ({strb, M, irq_mask, pc_target} !== {6'b100100, tm, m_i, vec}) begin
        miscompares++;
        $display("FAIL vector_cycle: got s=%b M=%b I=%b pc=%h want s=%b M=%b I=%b pc=%h",
                 strb, M, irq_mask, pc_target, 6'b100100, tm, m_i, vec);
      end
      m_mode = tm;
      m_i    = 1'b1;
      @(negedge clk); #1;
    end else if (ev == 4) begin
      vectors++;
      if ({strb, pc_target, nzcv_out} !== {6'b100110, lr, sp[31:28]}) begin
        miscompares++;
        $display("FAIL ret_cycle: got s=%b pc=%h nzcv=%b want s=%b pc=%h nzcv=%b",
                 strb, pc_target, nzcv_out, 6'b100110, lr, sp[31:28]);
      end
      m_mode = sp[4:0];
      m_i    = sp[7];
      @(negedge clk); #1;
    end
    vectors++;
    if ({strb, M, irq_mask} !== {6'b0, m_mode, m_i}) begin
      miscompares++;
      $display("FAIL after_boundary ev=%0d: got s=%b M=%b I=%b want s=000000 M=%b I=%b",
               ev, strb, M, irq_mask, m_mode, m_i);
    end
  endtask

  task automatic do_msr(input logic [31:0] d);
    bit ok;
    @(negedge clk);
    msr_we = 1'b1; msr_data = d;
    ok = (m_mode != USR) && legal_mode(d[4:0]);
    #1;
    vectors++;
    if (strb !== {5'b0, !ok}) begin
      miscompares++;
      $display("FAIL msr_strobes data=%h: got %b want %b", d, strb, {5'b0, !ok});
    end
    @(negedge clk);
    msr_we = 1'b0;
    if (ok) begin
      m_mode = d[4:0];
      m_i    = d[7];
    end
    #1;
    vectors++;
    if ({strb, M, irq_mask} !== {6'b0, m_mode, m_i}) begin
      miscompares++;
      $display("FAIL msr_result data=%h: got M=%b I=%b want M=%b I=%b", d, M, irq_mask, m_mode, m_i);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({strb, M, irq_mask, lr_data, spsr_data, pc_target, nzcv_out} !==
        {6'b0, SVC, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got s=%b M=%b I=%b lr=%h spsr=%h pc=%h nzcv=%b want zeros M=%b I=1",
               strb, M, irq_mask, lr_data, spsr_data, pc_target, nzcv_out, SVC);
    end
    rst = 1'b0;
    m_mode = SVC;
    m_i    = 1'b1;
  endtask

  task automatic test_und_entry;
    boundary(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 4'hA, 32'h0, 32'h0);
  endtask

  task automatic test_irq_entry;
    do_msr(32'h0000_0013);
    boundary(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 4'h3, 32'h0, 32'h0);
    irq_req = 1'b0;
  endtask

  task automatic test_priority;
    do_msr(32'h0000_0013);
    boundary(1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 4'h5, 32'h0, 32'h0);
    do_msr(32'h0000_001B);
    boundary(1'b0, 1'b0, 1'b0, 1'b1, 32'h410, 4'h1, 32'h0, 32'h0);
    irq_req = 1'b0;
  endtask

  task automatic test_eret;
    do_msr(32'h0000_0092);
    boundary(1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 4'h0, 32'h204, 32'h6000_0010);
  endtask

  task automatic test_usr_priv;
    boundary(1'b0, 1'b0, 1'b1, 1'b0, 32'h600, 4'h0, 32'h44, 32'h0000_0013);
    do_msr(32'h0000_0013);
    boundary(1'b0, 1'b1, 1'b0, 1'b0, 32'h610, 4'h2, 32'h0, 32'h0);
    do_msr(32'h0000_0005);
  endtask

  task automatic test_rst_mid;
    @(negedge clk);
    inst_done = 1'b1; und_ins = 1'b1; pc_in = 32'h300; irq_req = 1'b0;
    @(negedge clk);
    inst_done = 1'b0; und_ins = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (strb !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_in_save_strobes: got %b want 000000", strb);
    end
    @(negedge clk);
    rst = 1'b0;
    m_mode = SVC;
    m_i    = 1'b1;
    #1;
    vectors++;
    if ({strb, M, irq_mask} !== {6'b0, SVC, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_in_save_after: got s=%b M=%b I=%b want s=000000 M=%b I=1", strb, M, irq_mask, SVC);
    end
    @(negedge clk); #1;
    vectors++;
    if (strb !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_in_save_no_pc_load: got %b want 000000", strb);
    end
  endtask

  task automatic test_random;
    logic [4:0] modes [4];
    logic [31:0] d, sp;
    modes[0] = USR; modes[1] = IRQ; modes[2] = SVC; modes[3] = UND;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(3) == 0) begin
        d = $urandom;
        if ($urandom_range(3) != 0) d[4:0] = modes[$urandom_range(3)];
        do_msr(d);
      end else begin
        sp = $urandom;
        sp[4:0] = modes[$urandom_range(3)];
        boundary(($urandom_range(7) == 0), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(1) == 0), $urandom, 4'($urandom), $urandom, sp);
      end
    end
    irq_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inst_done = 1'b0; und_ins = 1'b0; swi_ins = 1'b0; eret_req = 1'b0;
    irq_req = 1'b0; msr_we = 1'b0; msr_data = 32'h0; pc_in = 32'h0; nzcv_in = 4'h0;
    lr_in = 32'h0; spsr_in = 32'h0; m_mode = SVC; m_i = 1'b1;
    test_reset;
    test_und_entry;
    test_irq_entry;
    test_priority;
    test_eret;
    test_usr_priv;
    test_rst_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
